// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: shared UART types, parity encodings and bit-period helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uartState_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Integer-truncated clocks per bit; the line rate error this implies is accepted.
  function automatic int bitCycles(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  function automatic logic parityBit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// uart_baud_gen: bit-period counter with restart, ticks on the last clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int c_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_send.sv
// ============================================================================
// uart_send: UART transmitter, 8 data bits LSB first, optional parity, 1/2 stop
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       SendEn,
  input  logic [7:0] SendData,
  output logic       SendBusy,
  output logic       SendDone,
  output logic       UartTx
);

  localparam int c_BIT_CYCLES = bitCycles(CLK_FREQ, BAUD);
  localparam logic c_LAST_STOP = 1'(STOP_BITS - 1);

  uartState_t r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitIdx;
  logic       r_stopIdx;
  logic       r_parBit;
  logic       r_busy;
  logic       r_done;
  logic       r_tx;

  logic       w_accept;
  logic       w_tick;

  // Accepting a byte restarts the bit timer so the start bit is a full period.
  assign w_accept = SendEn && !r_busy && (r_state == ST_IDLE);

  uart_baud_gen #(
    .BIT_CYCLES(c_BIT_CYCLES)
  ) u_baudGen (
    .clk    (clk),
    .rstn   (rstn),
    .restart(w_accept),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_parBit  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= SendData;
            r_parBit  <= parityBit(SendData, PARITY);
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_busy    <= 1'b1;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bitIdx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                r_tx    <= r_parBit;
                r_state <= ST_PARITY;
              end else begin
                r_tx      <= 1'b1;
                r_stopIdx <= 1'b0;
                r_state   <= ST_STOP;
              end
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx      <= 1'b1;
            r_stopIdx <= 1'b0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_stopIdx == c_LAST_STOP) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_stopIdx <= 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign SendBusy = r_busy;
  assign SendDone = r_done;
  assign UartTx   = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_send.sv
// ============================================================================
// tb_uart_send: self-checking bench for uart_send (default and 8E2 instances)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_send;

  localparam int B = 434;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    int         par;
    int         stopB;
    int         expLen;
    int         expPar;
    bit         mid;
    bit         tail;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       busy0, busy1, done0, done1, tx0, tx1;
  logic       sel = 1'b0;
  logic       txS, busyS, doneS;
  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[5];

  always #10 clk = ~clk;

  uart_send dut0 (
    .clk(clk), .rstn(rstn), .SendEn(en0), .SendData(d0),
    .SendBusy(busy0), .SendDone(done0), .UartTx(tx0)
  );

  uart_send #(
    .CLK_FREQ(50_000_000), .BAUD(115200), .PARITY(2), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rstn(rstn), .SendEn(en1), .SendData(d1),
    .SendBusy(busy1), .SendDone(done1), .UartTx(tx1)
  );

  always_comb begin
    txS   = sel ? tx1 : tx0;
    busyS = sel ? busy1 : busy0;
    doneS = sel ? done1 : done0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] v);
    if (sel) begin en1 = e; d1 = v; end
    else     begin en0 = e; d0 = v; end
  endtask

  // Sends one byte and checks every cycle of the frame against the bit list.
  task automatic frame(input logic s, input logic [7:0] d, input int par, input int stopB,
                       input int expLen, input int expPar, input bit mid, input bit tail);
    logic lv[$];
    int   errs[16];
    int   c = 0;
    int   doneErr = 0;
    int   busyHi = 0;
    int   parSeen = -1;
    logic p;
    sel = s;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (par != 0) begin
      p = ^d;
      if (par == 1) p = ~p;
      lv.push_back(p);
    end
    for (int i = 0; i < stopB; i++) lv.push_back(1'b1);
    foreach (errs[i]) errs[i] = 0;

    drive(1'b1, d);
    @(posedge clk); #1;
    drive(1'b0, 8'($urandom));
    while (busyS && c < 20000) begin
      if (c / B < lv.size()) begin
        if (txS !== lv[c / B]) errs[c / B]++;
      end
      if (doneS) doneErr++;
      if (par != 0 && c == 9 * B + B / 2) parSeen = int'(txS);
      if (mid && c == 2000) drive(1'b1, 8'hFF);
      if (mid && c == 2001) drive(1'b0, 8'($urandom));
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("busyLen d=%02h", d), c, expLen);
    for (int i = 0; i < lv.size(); i++)
      chk($sformatf("level%0d_badCycles d=%02h", i, d), errs[i], 0);
    chk("doneInFrame", doneErr, 0);
    chk("doneAtEnd", int'(doneS), 1);
    chk("txAtEnd", int'(txS), 1);
    if (par != 0) chk($sformatf("parityBit d=%02h", d), parSeen, expPar);
    if (tail) begin
      @(posedge clk); #1;
      chk("doneOneCycle", int'(doneS), 0);
      for (int i = 0; i < 20; i++) begin
        if (busyS || !txS) busyHi++;
        @(posedge clk); #1;
      end
      chk("idleAfterFrame", busyHi, 0);
    end
  endtask

  initial begin
    int   doneSeen;
    logic [7:0] r;
    logic p;

    vecs[0] = '{1'b0, 8'h12, 0, 1, 4340, 0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 8'h3C, 0, 1, 4340, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hA5, 0, 1, 4340, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h07, 2, 2, 5208, 1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 2, 2, 5208, 1, 1'b0, 1'b1};

    #100;
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    en0 = 1'b1; d0 = 8'h5A;
    @(posedge clk); @(posedge clk); #1;
    en0 = 1'b0;
    chk("rst_enIgnoredBusy", int'(busy0), 0);
    chk("rst_enIgnoredTx", int'(tx0), 1);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    foreach (vecs[i])
      frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stopB,
            vecs[i].expLen, vecs[i].expPar, vecs[i].mid, vecs[i].tail);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      frame(1'b0, r, 0, 1, 10 * B, 0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      r = 8'($urandom);
      p = ^r;
      frame(1'b1, r, 2, 2, 12 * B, int'(p), 1'b0, 1'b1);
    end

    // Abort in the middle of the data bits.
    sel = 1'b0;
    drive(1'b1, 8'h33);
    @(posedge clk); #1;
    drive(1'b0, 8'h00);
    repeat (3 * B) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_tx", int'(tx0), 1);
    chk("abort_busy", int'(busy0), 0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done0) doneSeen++;
      @(posedge clk); #1;
    end
    chk("abort_noDone", doneSeen, 0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    frame(1'b0, 8'h55, 0, 1, 4340, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
